// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: sequential step, stall, redirect,
// trap vectoring and call/return through a circular return-address stack.
module pc_gen #(
  parameter int              PC_W      = 32,
  parameter int              STEP      = 4,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter logic [PC_W-1:0] TRAP_VEC  = PC_W'('h100),
  parameter int              RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         redirect_valid,
  input  logic [PC_W-1:0]              redirect_target,
  input  logic                         call_valid,
  input  logic [PC_W-1:0]              call_target,
  input  logic                         ret_valid,
  input  logic                         trap,
  output logic [PC_W-1:0]              pc,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ret_err,
  output logic                         flush
);

  localparam int              PTR_W      = $clog2(RAS_DEPTH);
  localparam int              CNT_W      = PTR_W + 1;
  localparam logic [PC_W-1:0] STEP_V     = PC_W'(STEP);
  localparam logic [PC_W-1:0] ALIGN_MASK = ~(STEP_V - PC_W'(1));
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(RAS_DEPTH);

  logic [PC_W-1:0]  pc_q, pc_d, pc_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d, ptr_top;
  logic             ret_err_q, ret_err_d;
  logic             flush_q, flush_d;
  logic             push_en;
  logic [PC_W-1:0]  ras_q [RAS_DEPTH];
  logic [PC_W-1:0]  ras_d [RAS_DEPTH];

  assign pc_inc  = pc_q + STEP_V;
  assign ptr_top = ptr_q - PTR_W'(1);

  // ptr_q names the next free slot; when full it also names the oldest entry,
  // so a push into a full stack naturally overwrites the oldest return address.
  always_comb begin
    pc_d      = pc_inc;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    ret_err_d = 1'b0;
    flush_d   = 1'b0;
    push_en   = 1'b0;
    if (trap) begin
      pc_d    = TRAP_VEC;
      flush_d = 1'b1;
    end else if (redirect_valid) begin
      pc_d    = redirect_target & ALIGN_MASK;
      flush_d = 1'b1;
    end else if (call_valid) begin
      pc_d    = call_target & ALIGN_MASK;
      push_en = 1'b1;
      ptr_d   = ptr_q + PTR_W'(1);
      if (cnt_q != FULL_CNT) cnt_d = cnt_q + CNT_W'(1);
      flush_d = 1'b1;
    end else if (ret_valid) begin
      flush_d = 1'b1;
      if (cnt_q != '0) begin
        pc_d  = ras_q[ptr_top];
        ptr_d = ptr_top;
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        pc_d      = TRAP_VEC;
        ret_err_d = 1'b1;
      end
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  always_comb begin
    ras_d = ras_q;
    if (push_en) ras_d[ptr_q] = pc_inc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_VEC;
      cnt_q     <= '0;
      ptr_q     <= '0;
      ret_err_q <= 1'b0;
      flush_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      ret_err_q <= ret_err_d;
      flush_q   <= flush_d;
    end
  end

  // Stack contents are don't-care after reset, so the storage has no reset.
  always_ff @(posedge clk) begin
    ras_q <= ras_d;
  end

  assign pc        = pc_q;
  assign ras_count = cnt_q;
  assign ret_err   = ret_err_q;
  assign flush     = flush_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: a queue-based reference model predicts every
// cycle's outputs; a separate monitor compares them against the DUT.
module tb_pc_gen;

  localparam int              PC_W      = 12;
  localparam int              STEP      = 4;
  localparam int              RAS_DEPTH = 4;
  localparam int              CNT_W     = 3;
  localparam logic [PC_W-1:0] RESET_VEC = 12'h000;
  localparam logic [PC_W-1:0] TRAP_VEC  = 12'h100;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              stall = 1'b0;
  logic              redirect_valid = 1'b0;
  logic [PC_W-1:0]   redirect_target = '0;
  logic              call_valid = 1'b0;
  logic [PC_W-1:0]   call_target = '0;
  logic              ret_valid = 1'b0;
  logic              trap = 1'b0;
  logic [PC_W-1:0]   pc;
  logic [CNT_W-1:0]  ras_count;
  logic              ret_err;
  logic              flush;

  pc_gen #(
    .PC_W(PC_W), .STEP(STEP), .RESET_VEC(RESET_VEC),
    .TRAP_VEC(TRAP_VEC), .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .call_valid(call_valid), .call_target(call_target),
    .ret_valid(ret_valid), .trap(trap),
    .pc(pc), .ras_count(ras_count), .ret_err(ret_err), .flush(flush)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [CNT_W-1:0] cnt;
    logic             err;
    logic             flush;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cycle_no = 0;

  // Reference model: plain integers and a queue used as an unbounded stack
  // that discards its oldest element once it holds more than RAS_DEPTH.
  int unsigned m_pc;
  int unsigned m_ras[$];

  localparam int unsigned PC_MASK    = (1 << PC_W) - 1;
  localparam int unsigned ALIGN_MASK = PC_MASK & ~(STEP - 1);

  task automatic check_output(input string name, input logic [31:0] got,
                              input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", name, got, want);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_VEC;
    m_ras.delete();
  endtask

  task automatic drive_cycle(input bit s, input bit rv, input int unsigned rt,
                             input bit cv, input int unsigned ct,
                             input bit rtv, input bit tr);
    exp_t e;
    bit   err_e = 0;
    bit   fl_e  = 0;
    stall           = s;
    redirect_valid  = rv;
    redirect_target = rt[PC_W-1:0];
    call_valid      = cv;
    call_target     = ct[PC_W-1:0];
    ret_valid       = rtv;
    trap            = tr;
    if (tr) begin
      m_pc = TRAP_VEC; fl_e = 1;
    end else if (rv) begin
      m_pc = rt & ALIGN_MASK; fl_e = 1;
    end else if (cv) begin
      m_ras.push_back((m_pc + STEP) & PC_MASK);
      if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
      m_pc = ct & ALIGN_MASK; fl_e = 1;
    end else if (rtv) begin
      fl_e = 1;
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else begin m_pc = TRAP_VEC; err_e = 1; end
    end else if (!s) begin
      m_pc = (m_pc + STEP) & PC_MASK;
    end
    e.pc    = m_pc[PC_W-1:0];
    e.cnt   = CNT_W'(m_ras.size());
    e.err   = err_e;
    e.flush = fl_e;
    exp_q.push_back(e);
  endtask

  task automatic apply_stimulus(input bit s, input bit rv, input int unsigned rt,
                                input bit cv, input int unsigned ct,
                                input bit rtv, input bit tr);
    @(negedge clk);
    drive_cycle(s, rv, rt, cv, ct, rtv, tr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic redirect(input int unsigned t);
    apply_stimulus(0, 1, t, 0, 0, 0, 0);
  endtask

  task automatic call(input int unsigned t);
    apply_stimulus(0, 0, 0, 1, t, 0, 0);
  endtask

  task automatic ret();
    apply_stimulus(0, 0, 0, 0, 0, 1, 0);
  endtask

  // Reset lands between edges, after the monitor has consumed the last
  // prediction, and must take effect without waiting for a clock edge.
  task automatic async_reset_then_ret(input string tag);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_output({tag, "_pc"},    32'(pc),        32'(RESET_VEC));
    check_output({tag, "_cnt"},   32'(ras_count), 32'd0);
    check_output({tag, "_err"},   32'(ret_err),   32'd0);
    check_output({tag, "_flush"}, 32'(flush),     32'd0);
    check_output({tag, "_queue"}, 32'(exp_q.size()), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive_cycle(0, 0, 0, 0, 0, 1, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cycle_no++;
      if (!rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output($sformatf("cycle%0d", cycle_no),
                     32'({pc, ras_count, ret_err, flush}), 32'(e));
      end
    end
  end

  initial begin : driver
    #2;
    check_output("reset_pc",    32'(pc),        32'(RESET_VEC));
    check_output("reset_cnt",   32'(ras_count), 32'd0);
    check_output("reset_err",   32'(ret_err),   32'd0);
    check_output("reset_flush", 32'(flush),     32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive_cycle(0, 0, 0, 0, 0, 0, 0);

    // Free-running increment across the 12-bit wrap point.
    idle(1030);

    // Stall holds, a redirect during stall is taken and aligned.
    redirect(12'h020);
    repeat (3) apply_stimulus(1, 0, 0, 0, 0, 0, 0);
    apply_stimulus(1, 1, 12'h047, 0, 0, 0, 0);
    idle(2);

    // Everything at once with one RAS entry: trap wins, stack untouched.
    call(12'h080);
    apply_stimulus(1, 1, 12'h555, 1, 12'h666, 1, 1);
    idle(1);
    ret();

    // Nested call/return.
    redirect(12'h010);
    call(12'h200);
    call(12'h300);
    call(12'h500);
    repeat (3) ret();
    idle(1);

    // Overflow then return on an empty stack.
    redirect(12'h040);
    for (int i = 0; i < 5; i++) call(12'h400 + 12'h40 * i);
    repeat (5) ret();
    idle(2);

    // Asynchronous reset with three live entries at pc=0x300.
    redirect(12'h010);
    call(12'h100);
    call(12'h200);
    call(12'h300);
    async_reset_then_ret("midreset");
    idle(2);

    // Randomised mixes of all controls, unaligned targets included.
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) async_reset_then_ret("randreset");
      apply_stimulus($urandom_range(0, 99) < 20,
                     $urandom_range(0, 99) < 10, $urandom_range(0, 4095),
                     $urandom_range(0, 99) < 15, $urandom_range(0, 4095),
                     $urandom_range(0, 99) < 15,
                     $urandom_range(0, 99) < 3);
    end
    idle(2);

    @(posedge clk);
    #3;
    check_output("drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
